// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the ALU pipeline stage.
package alu_pkg;

    // 3-bit opcodes, fully decoded
    localparam logic [2:0] OP_CLR  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_RSUB = 3'b010;
    localparam logic [2:0] OP_ADD  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_AND  = 3'b110;
    localparam logic [2:0] OP_SET  = 3'b111;

    // Positions inside the 4-bit flags word {carry, zero, neg, ovf}
    localparam int unsigned FLG_C  = 3;
    localparam int unsigned FLG_Z  = 2;
    localparam int unsigned FLG_N  = 1;
    localparam int unsigned FLG_V  = 0;
    localparam int unsigned FLAG_W = 4;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: eight operations, carry/borrow and signed
// overflow from a WIDTH+1 bit datapath, optional unsigned saturation.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    input  logic [2:0]        s,
    output logic [WIDTH-1:0]  result,
    output logic [FLAG_W-1:0] flags
);

    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH:0]   rsub_w;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;
    logic             sign_a;
    logic             sign_b;

    assign sign_a = op_a[WIDTH-1];
    assign sign_b = op_b[WIDTH-1];

    // Extended-width add and both subtract directions; MSB is carry or borrow
    always_comb begin
        add_w  = {1'b0, op_a} + {1'b0, op_b};
        sub_w  = {1'b0, op_a} - {1'b0, op_b};
        rsub_w = {1'b0, op_b} - {1'b0, op_a};
    end

    // Opcode decode: raw result plus carry/overflow of the raw operation
    always_comb begin
        raw   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (s)
            OP_CLR: raw = '0;
            OP_SUB: begin
                raw   = sub_w[WIDTH-1:0];
                carry = sub_w[WIDTH];
                ovf   = (sign_a != sign_b) && (sub_w[WIDTH-1] != sign_a);
            end
            OP_RSUB: begin
                raw   = rsub_w[WIDTH-1:0];
                carry = rsub_w[WIDTH];
                ovf   = (sign_b != sign_a) && (rsub_w[WIDTH-1] != sign_b);
            end
            OP_ADD: begin
                raw   = add_w[WIDTH-1:0];
                carry = add_w[WIDTH];
                ovf   = (sign_a == sign_b) && (add_w[WIDTH-1] != sign_a);
            end
            OP_XOR:  raw = op_a ^ op_b;
            OP_OR:   raw = op_a | op_b;
            OP_AND:  raw = op_a & op_b;
            OP_SET:  raw = '1;
            default: raw = '0;
        endcase
    end

    // Unsigned clamp: add overflow pins high, subtract underflow pins low
    always_comb begin
        res = raw;
        if ((SATURATE != 0) && carry) begin
            if (s == OP_ADD) begin
                res = '1;
            end else if ((s == OP_SUB) || (s == OP_RSUB)) begin
                res = '0;
            end
        end
    end

    // Zero and negative follow the final result; carry/ovf follow the raw op
    always_comb begin
        flags        = '0;
        flags[FLG_C] = carry;
        flags[FLG_Z] = (res == '0);
        flags[FLG_N] = res[WIDTH-1];
        flags[FLG_V] = ovf;
        result       = res;
    end

endmodule

// File: rtl/alu_pipe.sv
// Single registered ALU stage with valid/ready on both sides and an
// accumulator that can replace operand A.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [2:0]        s,
    input  logic              acc_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  z,
    output logic [FLAG_W-1:0] flags,
    output logic [WIDTH-1:0]  acc
);

    logic              out_valid_q;
    logic              out_valid_d;
    logic [WIDTH-1:0]  z_q;
    logic [WIDTH-1:0]  z_d;
    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic [WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]  acc_d;

    logic              accept;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  core_z;
    logic [FLAG_W-1:0] core_flags;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    // Pre-update accumulator feeds A, so consecutive accumulating ops chain
    assign op_a     = acc_sel ? acc_q : a;

    alu_core #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_core (
        .op_a   (op_a),
        .op_b   (b),
        .s      (s),
        .result (core_z),
        .flags  (core_flags)
    );

    // Next-state: load on accept, drop valid when drained, otherwise hold
    always_comb begin
        out_valid_d = out_valid_q;
        z_d         = z_q;
        flags_d     = flags_q;
        acc_d       = acc_q;
        if (accept) begin
            out_valid_d = 1'b1;
            z_d         = core_z;
            flags_d     = core_flags;
            acc_d       = core_z;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and accumulator, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            z_q         <= '0;
            flags_q     <= '0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            flags_q     <= flags_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign z         = z_q;
    assign flags     = flags_q;
    assign acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: a wrapping and a saturating instance share stimulus;
// an integer-arithmetic reference model is compared every cycle, and
// directed vectors carry hand-computed literal expectations.
module tb_alu_pipe;

    localparam int unsigned W = 8;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         acc_sel   = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic [2:0]   s         = '0;

    logic         in_ready,  in_ready_s;
    logic         out_valid, out_valid_s;
    logic [W-1:0] z,   z_s;
    logic [W-1:0] acc, acc_s;
    logic [3:0]   flags, flags_s;

    int n_vec  = 0;
    int n_err  = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .SATURATE(0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .s(s), .acc_sel(acc_sel), .out_valid(out_valid),
        .out_ready(out_ready), .z(z), .flags(flags), .acc(acc)
    );

    alu_pipe #(.WIDTH(W), .SATURATE(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .s(s), .acc_sel(acc_sel), .out_valid(out_valid_s),
        .out_ready(out_ready), .z(z_s), .flags(flags_s), .acc(acc_s)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference ALU from plain integer arithmetic on unsigned and signed views
    function automatic void ref_alu(input int op, input int ua, input int ub, input bit sat,
                                    output logic [7:0] rz, output logic [3:0] rf);
        int r, sa, sb, sr;
        bit c, v;
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (op)
            1: begin r = ua - ub; c = (ua < ub); sr = sa - sb; v = (sr > 127) || (sr < -128); if (sat && c) r = 0; end
            2: begin r = ub - ua; c = (ub < ua); sr = sb - sa; v = (sr > 127) || (sr < -128); if (sat && c) r = 0; end
            3: begin r = ua + ub; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); if (sat && c) r = 255; end
            4: r = ua ^ ub;
            5: r = ua | ub;
            6: r = ua & ub;
            7: r = 255;
            default: r = 0;
        endcase
        r  = r & 255;
        rz = r[7:0];
        rf = {c, (r == 0), (r > 127), v};
    endfunction

    logic       m_valid = 1'b0;
    logic [7:0] m_z   [2] = '{default: '0};
    logic [7:0] m_acc [2] = '{default: '0};
    logic [3:0] m_flg [2] = '{default: '0};

    // Reference stage: accept rule, drain rule, accumulator operand selection
    always @(posedge clk or negedge rst_n) begin : model
        logic [7:0] mz;
        logic [3:0] mf;
        int         opa;
        if (!rst_n) begin
            m_valid <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_z[k]   <= '0;
                m_acc[k] <= '0;
                m_flg[k] <= '0;
            end
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid <= 1'b1;
            for (int k = 0; k < 2; k++) begin
                opa = acc_sel ? int'(m_acc[k]) : int'(a);
                ref_alu(int'(s), opa, int'(b), (k == 1), mz, mf);
                m_z[k]   <= mz;
                m_flg[k] <= mf;
                m_acc[k] <= mz;
            end
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
        end
    end

    // Per-cycle comparison of both instances against the reference
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out_valid",   out_valid,   m_valid);
            chk("in_ready",    in_ready,    !m_valid || out_ready);
            chk("z",           z,           m_z[0]);
            chk("flags",       flags,       m_flg[0]);
            chk("acc",         acc,         m_acc[0]);
            chk("out_valid_s", out_valid_s, m_valid);
            chk("in_ready_s",  in_ready_s,  !m_valid || out_ready);
            chk("z_s",         z_s,         m_z[1]);
            chk("flags_s",     flags_s,     m_flg[1]);
            chk("acc_s",       acc_s,       m_acc[1]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep_z [8] = '{8'h00, 8'h02, 8'hFE, 8'h08, 8'h06, 8'h07, 8'h01, 8'hFF};
    logic [3:0] sweep_f [8] = '{4'b0100, 4'b0000, 4'b1010, 4'b0000,
                                4'b0000, 4'b0000, 4'b0000, 4'b0010};

    initial begin
        // Reset state
        step();
        step();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_z",         z,         8'h00);
        chk("rst_flags",     flags,     4'h0);
        chk("rst_acc",       acc,       8'h00);
        chk("rst_in_ready",  in_ready,  1'b1);
        cmp_en = 1'b1;
        #2 rst_n = 1'b1;

        // Opcode sweep a=5, b=3
        in_valid = 1'b1;
        a = 8'h05;
        b = 8'h03;
        for (int i = 0; i < 8; i++) begin
            s = 3'(i);
            step();
            chk("sweep_z",     z,     sweep_z[i]);
            chk("sweep_flags", flags, sweep_f[i]);
        end

        // Signed overflow
        a = 8'h7F; b = 8'h01; s = 3'b011;
        step();
        chk("ovf_add_z",     z,     8'h80);
        chk("ovf_add_flags", flags, 4'b0011);
        a = 8'h80; b = 8'h01; s = 3'b001;
        step();
        chk("ovf_sub_z",     z,     8'h7F);
        chk("ovf_sub_flags", flags, 4'b0001);

        // Saturation versus wrap
        a = 8'hF0; b = 8'h20; s = 3'b011;
        step();
        chk("sat_add_z",      z_s,     8'hFF);
        chk("sat_add_flags",  flags_s, 4'b1010);
        chk("wrap_add_z",     z,       8'h10);
        chk("wrap_add_flags", flags,   4'b1000);
        a = 8'h03; b = 8'h05; s = 3'b001;
        step();
        chk("sat_sub_z",      z_s,     8'h00);
        chk("sat_sub_flags",  flags_s, 4'b1100);
        chk("wrap_sub_z",     z,       8'hFE);
        chk("wrap_sub_flags", flags,   4'b1010);

        // Backpressure
        a = 8'h05; b = 8'h03; s = 3'b011;
        step();
        chk("bp_first_z", z, 8'h08);
        out_ready = 1'b0;
        a = 8'h01; b = 8'h01; s = 3'b100;
        #1;
        chk("bp_in_ready_low", in_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_z",     z,         8'h08);
            chk("bp_hold_rdy",   in_ready,  1'b0);
            chk("bp_hold_acc",   acc,       8'h08);
            chk("bp_hold_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", in_ready, 1'b1);
        step();
        chk("bp_next_z",     z,     8'h00);
        chk("bp_next_flags", flags, 4'b0100);
        chk("bp_next_acc",   acc,   8'h00);

        // Accumulator chain from reset
        #2 rst_n = 1'b0;
        step();
        #2 rst_n = 1'b1;
        acc_sel = 1'b1;
        a = 8'hAA; b = 8'h01; s = 3'b011;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("chain_z",   z,   8'(i));
            chk("chain_z_s", z_s, 8'(i));
        end
        chk("chain_acc",   acc,   8'h04);
        chk("chain_acc_s", acc_s, 8'h04);

        // Asynchronous reset mid-cycle with a result held
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_z",         z,         8'h00);
        chk("arst_flags",     flags,     4'h0);
        chk("arst_acc",       acc,       8'h00);
        chk("arst_acc_s",     acc_s,     8'h00);
        step();
        #2 rst_n = 1'b1;
        in_valid = 1'b1;
        a = 8'h05; b = 8'h03; s = 3'b011;
        step();
        chk("post_rst_z",     z,         8'h03);
        chk("post_rst_acc",   acc,       8'h03);
        chk("post_rst_valid", out_valid, 1'b1);
        in_valid = 1'b0;
        step();
        chk("drain_valid", out_valid, 1'b0);
        chk("drain_z",     z,         8'h03);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
